// File: rtl/serial_sample_tx.sv
// serial_sample_tx
//   Host-side transmitter. Parallel samples enter through a valid/ready
//   handshake into a small FIFO and are shifted out MSB first, one bit per
//   enabled cycle. An optional idle gap separates consecutive serial words.
//
// Parameters
//   DATA_WIDTH  bits per sample and per serial word
//   FIFO_DEPTH  sample FIFO entries (power of two, >= 2)
//   GAP_CYCLES  idle enabled cycles between serial words (0 = back-to-back)
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_en           clock enable for the serial side; FIFO write side ignores it
//   iv_din         parallel sample
//   i_din_valid    iv_din valid
//   o_din_ready    FIFO not full
//   o_dout         serial bit, MSB first (0 when o_dout_valid is 0)
//   o_dout_valid   o_dout carries a word bit this cycle
//   o_busy         word in flight (SHIFT or GAP)
//   ov_fifo_level  entries currently stored
module serial_sample_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [DATA_WIDTH-1:0]       iv_din,
  input  logic                        i_din_valid,
  output logic                        o_din_ready,
  output logic                        o_dout,
  output logic                        o_dout_valid,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] ov_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit            HAS_GAP    = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [LW-1:0]         count_reg;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign fifo_full  = (count_reg == FULL_LEVEL);
  assign fifo_empty = (count_reg == '0);
  // Ready comes only from registered count, so a same-cycle pop never
  // opens a slot while full.
  assign push       = i_din_valid && !fifo_full;
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= iv_din;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------
  state_t                state_reg;
  logic [DATA_WIDTH-1:0] sr_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic [GW-1:0]         gap_cnt_reg;
  logic                  dout_reg;
  logic                  dout_valid_reg;

  // Pop in IDLE, or on the last bit of a word when there is no gap so the
  // next word follows without a dead cycle.
  always_comb begin
    pop = 1'b0;
    if (i_en && !fifo_empty) begin
      if (state_reg == ST_IDLE) begin
        pop = 1'b1;
      end else if (state_reg == ST_SHIFT && bit_cnt_reg == '0 && !HAS_GAP) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      sr_reg         <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      dout_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else if (!i_en) begin
      // Pause: everything holds, only the valid strobe drops.
      dout_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            sr_reg      <= head;
            bit_cnt_reg <= BIT_LAST;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          dout_reg       <= sr_reg[DATA_WIDTH-1];
          dout_valid_reg <= 1'b1;
          sr_reg         <= sr_reg << 1;
          if (bit_cnt_reg == '0) begin
            if (HAS_GAP) begin
              gap_cnt_reg <= GAP_LOAD;
              state_reg   <= ST_GAP;
            end else if (pop) begin
              sr_reg      <= head;
              bit_cnt_reg <= BIT_LAST;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg - CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_din_ready   = !fifo_full;
  assign o_dout        = dout_reg;
  assign o_dout_valid  = dout_valid_reg;
  assign o_busy        = (state_reg != ST_IDLE);
  assign ov_fifo_level = count_reg;

endmodule

// File: tb/tb_serial_sample_tx.sv
// Directed bench for serial_sample_tx. Two instances share clock and reset:
// g_* uses GAP_CYCLES=2, b_* uses GAP_CYCLES=0. A negedge receiver rebuilds
// 24-bit words from the b_* stream by counting valid bits.
module tb_serial_sample_tx;
  localparam int DW = 24;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          g_en, g_din_valid, g_din_ready, g_dout, g_dout_valid, g_busy;
  logic [DW-1:0] g_din;
  logic [LW-1:0] g_level;
  logic          b_en, b_din_valid, b_din_ready, b_dout, b_dout_valid, b_busy;
  logic [DW-1:0] b_din;
  logic [LW-1:0] b_level;

  serial_sample_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .GAP_CYCLES(2)) dut_gap (
    .i_clk(clk), .i_rst(rst), .i_en(g_en), .iv_din(g_din), .i_din_valid(g_din_valid),
    .o_din_ready(g_din_ready), .o_dout(g_dout), .o_dout_valid(g_dout_valid),
    .o_busy(g_busy), .ov_fifo_level(g_level)
  );

  serial_sample_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .GAP_CYCLES(0)) dut_b2b (
    .i_clk(clk), .i_rst(rst), .i_en(b_en), .iv_din(b_din), .i_din_valid(b_din_valid),
    .o_din_ready(b_din_ready), .o_dout(b_dout), .o_dout_valid(b_dout_valid),
    .o_busy(b_busy), .ov_fifo_level(b_level)
  );

  int errors;
  int checks;

  // Receiver model: shifts in each valid bit, emits a word every DW bits.
  logic          rx_on = 1'b0;
  int            rx_bitcnt = 0;
  int            rx_nwords = 0;
  logic [DW-1:0] rx_sr = '0;
  logic [DW-1:0] rx_words [0:255];

  always @(negedge clk) begin
    if (rx_on && b_dout_valid) begin
      rx_sr = {rx_sr[DW-2:0], b_dout};
      rx_bitcnt++;
      if (rx_bitcnt == DW) begin
        if (rx_nwords < 256) rx_words[rx_nwords] = rx_sr;
        rx_nwords++;
        rx_bitcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (b_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", b_level); end
    checks++; if (b_din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", b_din_ready); end
    checks++; if (b_dout_valid !== 1'b0 || b_dout !== 1'b0) begin errors++; $display("FAIL reset_dout: valid=%b dout=%b want 0/0", b_dout_valid, b_dout); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b_busy); end
    checks++; if (g_din_ready !== 1'b1 || g_level !== 4'd0) begin errors++; $display("FAIL reset_gap_inst: ready=%b level=%0d want 1/0", g_din_ready, g_level); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_gap_single();
    logic [DW-1:0] w;
    w = 24'hA5F00F;
    g_din = w; g_din_valid = 1'b1;
    tick();                              // accept edge t
    g_din_valid = 1'b0;
    checks++; if (g_level !== 4'd1) begin errors++; $display("FAIL gap_level_after_write: got %0d want 1", g_level); end
    tick();                              // pop edge t+1
    checks++; if (g_dout_valid !== 1'b0 || g_busy !== 1'b1 || g_level !== 4'd0) begin
      errors++; $display("FAIL gap_pop: valid=%b busy=%b level=%0d want 0/1/0", g_dout_valid, g_busy, g_level);
    end
    for (int i = 0; i < DW; i++) begin
      tick();                            // edges t+2 .. t+25
      checks++;
      if (g_dout_valid !== 1'b1 || g_dout !== w[DW-1-i]) begin
        errors++; $display("FAIL gap_bit%0d: valid=%b dout=%b want 1/%b", i + 1, g_dout_valid, g_dout, w[DW-1-i]);
      end
    end
    tick();                              // t+26: second gap cycle
    checks++; if (g_dout_valid !== 1'b0 || g_busy !== 1'b1) begin errors++; $display("FAIL gap_hold: valid=%b busy=%b want 0/1", g_dout_valid, g_busy); end
    tick();                              // t+27: back in IDLE
    checks++; if (g_dout_valid !== 1'b0 || g_busy !== 1'b0) begin errors++; $display("FAIL gap_end: valid=%b busy=%b want 0/0", g_dout_valid, g_busy); end
    $display("test_gap_single done word=%06h", w);
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] e;
    e = {24'h000001, 24'hFFFFFE};
    b_en = 1'b1;
    b_din = 24'h000001; b_din_valid = 1'b1;
    tick();                              // t
    b_din = 24'hFFFFFE;
    tick();                              // t+1: push second, pop first
    b_din_valid = 1'b0;
    checks++; if (b_level !== 4'd1) begin errors++; $display("FAIL b2b_level: got %0d want 1", b_level); end
    for (int i = 0; i < 2 * DW; i++) begin
      tick();
      checks++;
      if (b_dout_valid !== 1'b1 || b_dout !== e[2*DW-1-i]) begin
        errors++; $display("FAIL b2b_bit%0d: valid=%b dout=%b want 1/%b", i + 1, b_dout_valid, b_dout, e[2*DW-1-i]);
      end
    end
    tick();
    checks++; if (b_dout_valid !== 1'b0 || b_busy !== 1'b0 || b_level !== 4'd0) begin
      errors++; $display("FAIL b2b_end: valid=%b busy=%b level=%0d want 0/0/0", b_dout_valid, b_busy, b_level);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] w [0:8];
    int base;
    int cyc;
    for (int k = 0; k < 9; k++) w[k] = DW'(32'hC30000 + k * 32'h000111);
    base = rx_nwords;
    rx_on = 1'b1;
    b_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_din = w[k]; b_din_valid = 1'b1;
      tick();
    end
    checks++; if (b_level !== 4'd8 || b_din_ready !== 1'b0) begin errors++; $display("FAIL full_at8: level=%0d ready=%b want 8/0", b_level, b_din_ready); end
    b_din = w[8];
    repeat (3) tick();
    checks++; if (b_level !== 4'd8 || b_din_ready !== 1'b0) begin errors++; $display("FAIL full_hold9: level=%0d ready=%b want 8/0", b_level, b_din_ready); end
    b_en = 1'b1;
    tick();                              // first pop, write still blocked
    checks++; if (b_level !== 4'd7 || b_din_ready !== 1'b1) begin errors++; $display("FAIL full_first_pop: level=%0d ready=%b want 7/1", b_level, b_din_ready); end
    tick();                              // ninth word accepted
    b_din_valid = 1'b0;
    checks++; if (b_level !== 4'd8) begin errors++; $display("FAIL full_ninth_accept: level=%0d want 8", b_level); end
    cyc = 0;
    while (rx_nwords < base + 9 && cyc < 400) begin tick(); cyc++; end
    checks++; if (rx_nwords < base + 9) begin errors++; $display("FAIL full_timeout: got %0d words want 9", rx_nwords - base); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (rx_words[base + k] !== w[k]) begin errors++; $display("FAIL full_word%0d: got %06h want %06h", k, rx_words[base + k], w[k]); end
    end
    repeat (2) tick();
    rx_on = 1'b0;
    $display("test_fifo_full done");
  endtask

  task automatic test_enable_pause();
    int base;
    int nbits;
    int cyc;
    base = rx_nwords;
    rx_on = 1'b1;
    b_en = 1'b1;
    b_din = 24'h123456; b_din_valid = 1'b1;
    tick();
    b_din_valid = 1'b0;
    nbits = 0; cyc = 0;
    while (nbits < 10 && cyc < 50) begin
      tick(); cyc++;
      if (b_dout_valid === 1'b1) nbits++;
    end
    checks++; if (nbits != 10) begin errors++; $display("FAIL pause_prefix: got %0d bits want 10", nbits); end
    b_en = 1'b0;
    for (int p = 0; p < 5; p++) begin
      tick();
      checks++;
      if (b_dout_valid !== 1'b0 || b_dout !== 1'b0) begin errors++; $display("FAIL pause_cycle%0d: valid=%b dout=%b want 0/0", p, b_dout_valid, b_dout); end
    end
    b_en = 1'b1;
    cyc = 0;
    while (rx_nwords < base + 1 && cyc < 50) begin tick(); cyc++; end
    checks++; if (rx_words[base] !== 24'h123456 || rx_nwords != base + 1) begin
      errors++; $display("FAIL pause_word: got %06h (words %0d) want 123456 (1)", rx_words[base], rx_nwords - base);
    end
    repeat (2) tick();
    rx_on = 1'b0;
    $display("test_enable_pause done");
  endtask

  task automatic test_reset_midword();
    int nbits;
    int seen;
    b_en = 1'b1;
    nbits = 0;
    for (int k = 0; k < 4; k++) begin
      b_din = DW'(32'h5A0000 + k); b_din_valid = 1'b1;
      tick();
      if (b_dout_valid === 1'b1) nbits++;
    end
    b_din_valid = 1'b0;
    checks++; if (b_level !== 4'd3) begin errors++; $display("FAIL rstmid_queued: level=%0d want 3", b_level); end
    while (nbits < 7) begin
      tick();
      if (b_dout_valid === 1'b1) nbits++;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (b_dout_valid !== 1'b0 || b_dout !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: valid=%b dout=%b busy=%b want 0/0/0", b_dout_valid, b_dout, b_busy);
    end
    checks++; if (b_din_ready !== 1'b1 || b_level !== 4'd0) begin errors++; $display("FAIL rstmid_fifo: ready=%b level=%0d want 1/0", b_din_ready, b_level); end
    repeat (2) tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (b_dout_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0 || b_level !== 4'd0) begin errors++; $display("FAIL rstmid_silent: valid cycles=%0d level=%0d want 0/0", seen, b_level); end
    $display("test_reset_midword done");
  endtask

  task automatic test_loopback();
    logic [DW-1:0] wq [0:99];
    int base;
    int idx;
    int cyc;
    logic acc;
    for (int i = 0; i < 100; i++) wq[i] = DW'($urandom);
    base = rx_nwords;
    rx_on = 1'b1;
    idx = 0; cyc = 0;
    while ((rx_nwords - base) < 100 && cyc < 20000) begin
      b_en = ($urandom_range(0, 3) != 0);
      if (idx < 100) begin
        b_din = wq[idx];
        b_din_valid = ($urandom_range(0, 1) == 1);
      end else begin
        b_din_valid = 1'b0;
      end
      acc = b_din_valid && b_din_ready;
      tick(); cyc++;
      if (acc) idx++;
    end
    b_din_valid = 1'b0;
    b_en = 1'b1;
    checks++; if ((rx_nwords - base) != 100) begin errors++; $display("FAIL loop_count: got %0d words want 100", rx_nwords - base); end
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (rx_words[base + i] !== wq[i]) begin errors++; $display("FAIL loop_word%0d: got %06h want %06h", i, rx_words[base + i], wq[i]); end
    end
    rx_on = 1'b0;
    $display("test_loopback done words=%0d", rx_nwords - base);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    g_en = 1'b1; g_din = '0; g_din_valid = 1'b0;
    b_en = 1'b1; b_din = '0; b_din_valid = 1'b0;
    test_reset();
    test_gap_single();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_fifo_full();
    test_enable_pause();
    test_reset_midword();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sample_tx.md
Name: serial_sample_tx

Overview:
Host-side transmitter that turns parallel samples into the bit-serial stream (i_din/i_din_valid) consumed by the filter chain's deserializer.
- Samples enter through a valid/ready handshake into a small FIFO.
- Each sample is shifted out MSB first, one bit per enabled cycle, with a configurable idle gap between words.
- Sits between the sample source and the serial input of the filter top level; the bench also uses it to drive the chain.

Parameters:
DATA_WIDTH, 24, bits per sample and per serial word
FIFO_DEPTH, 8, sample FIFO entries; power of two, >= 2
GAP_CYCLES, 0, idle enabled cycles between consecutive serial words (0 = back-to-back)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  clock enable for the serial side; FIFO write side ignores it
iv_din  in  DATA_WIDTH  parallel sample
i_din_valid  in  1  iv_din valid
o_din_ready  out  1  FIFO can accept; high = not full
o_dout  out  1  serial bit, MSB first
o_dout_valid  out  1  o_dout carries a word bit this cycle
o_busy  out  1  word in flight (SHIFT or GAP state)
ov_fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently stored

Behaviour:
Reset (async, active-high):
- All outputs 0 except o_din_ready = 1; FIFO emptied; state IDLE.
- Asserting reset mid-word discards the partial word. No further bits are emitted.

FIFO:
- Write on a rising edge when i_din_valid && o_din_ready.
- o_din_ready = !full, decoded from registered pointers/count. No write while full, even on a simultaneous pop.
- Simultaneous write and pop when not full: level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- ov_fifo_level updates on the edge after the write/pop.

State machine (states advance only when i_en = 1; i_en = 0 freezes state, counters and shift register, and forces o_dout_valid = 0):
- IDLE: if FIFO not empty, pop head into the shift register, bit_cnt = DATA_WIDTH-1, go to SHIFT.
- SHIFT:
  - Register o_dout = sr[DATA_WIDTH-1] and o_dout_valid = 1; shift sr left by one; decrement bit_cnt.
  - On bit_cnt == 0, if GAP_CYCLES > 0, load gap_cnt = GAP_CYCLES-1 and go to GAP.
  - Otherwise, if the FIFO is not empty, pop and reload immediately, staying in SHIFT. This gives gapless back-to-back words.
  - Otherwise go to IDLE.
- GAP: o_dout_valid = 0; decrement gap_cnt; at 0 go to IDLE.

Registered outputs:
- o_dout and o_dout_valid are registered.
- o_dout = 0 whenever o_dout_valid = 0.
- o_busy = 1 in SHIFT and GAP.

Latency: with the FIFO empty, IDLE and i_en held high, a sample accepted on edge t produces:
- FIFO non-empty after edge t;
- pop on edge t+1;
- first bit (MSB) valid after edge t+2;
- last bit (LSB) valid after edge t+2+DATA_WIDTH-1.

Framing:
- Exactly DATA_WIDTH valid bits per word, never split except by i_en pauses.
- The receiver counts valid bits, so gaps and pauses are transparent.

Test Plan:
1. DATA_WIDTH=24, GAP_CYCLES=2, i_en=1; write 0xA5F00F -> o_dout_valid high 24 consecutive cycles starting 2 edges after accept; bits 1010_0101_1111_0000_0000_1111; then o_dout_valid low; o_busy low after 2 gap cycles.
2. GAP_CYCLES=0; write 0x000001 then 0xFFFFFE back-to-back -> 48 contiguous valid cycles; bit 24 = 1, bit 25 = 1, bit 48 = 0; ov_fifo_level returns to 0.
3. FIFO_DEPTH=8, i_en=0; offer 9 writes -> first 8 accepted, o_din_ready low at level 8, 9th held. Raise i_en -> ready rises the edge after the first pop, and the 9th word is accepted and transmitted last.
4. Drop i_en for 5 cycles after bit 10 of 0x123456 -> o_dout_valid = 0 during the pause, then resumes at bit 11; serialized word still equals 0x123456.
5. Assert i_rst after bit 7 of a word with 3 words queued -> outputs 0 and o_din_ready = 1 immediately; level 0; no bits emitted after release until a new write.
6. Loopback into the deserializer (LENGTH=24) with 100 random words and random i_en -> deserialized words match the written sequence exactly, in order.
